audio_frame_pacer: RTL and testbench

- Sink end of the audiostream interface fed by the ADPCM/CDDA audio decoder.
- Accepts one mono or stereo-channel sample per handshake and pairs the samples into L/R frames.
- Buffers the frames in a FIFO and releases one frame per output tick, paced at the frame's native sample rate.
- Sits between the decoder and the DAC/mixer path and absorbs the decoder's bursty output.

---
 rtl/audio_frame_pacer.sv | 184 ++++++++++++++++++
 tb/tb_audio_frame_pacer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_pacer.sv
// Audiostream sink: pairs decoder samples into L/R frames, buffers them and
// releases one frame per tick of a fractional rate accumulator.
package audio_frame_pacer_pkg;
  typedef enum logic {kMono = 1'b0, kStereo = 1'b1} chan_e;
  typedef enum logic {kRate37_8 = 1'b0, kRate18_9 = 1'b1} rate_e;
  typedef enum logic [1:0] {k4Bps = 2'd0, k8Bps = 2'd1, k16Bps = 2'd2} bps_e;

  typedef struct packed {
    chan_e chan;
    rate_e rate;
    bps_e  bps;
  } header_coding_s;

  typedef enum logic [1:0] {
    RSEL_37800 = 2'd0,
    RSEL_18900 = 2'd1,
    RSEL_44100 = 2'd2
  } rate_sel_e;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
    rate_sel_e   rsel;
  } frame_s;
endpackage

module audio_frame_pacer
  import audio_frame_pacer_pkg::*;
#(
  parameter int unsigned CLK_HZ = 30_000_000,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [15:0]        in_sample,
  input  logic                      in_write,
  output logic                      in_strobe,
  input  logic                      in_channel,
  input  header_coding_s            in_coding,
  input  logic                      flush,
  output logic signed [15:0]        out_left,
  output logic signed [15:0]        out_right,
  output logic                      out_valid,
  output logic                      underflow,
  output logic [$clog2(DEPTH):0]    fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  function automatic logic [31:0] rate_hz_f(input rate_sel_e s);
    case (s)
      RSEL_44100: rate_hz_f = 32'd44100;
      RSEL_18900: rate_hz_f = 32'd18900;
      default:    rate_hz_f = 32'd37800;
    endcase
  endfunction

  function automatic rate_sel_e rate_sel_f(input header_coding_s c);
    if (c.bps == k16Bps)         rate_sel_f = RSEL_44100;
    else if (c.rate == kRate18_9) rate_sel_f = RSEL_18900;
    else                          rate_sel_f = RSEL_37800;
  endfunction

  logic            strobe_q, strobe_d;
  logic            pend_q, pend_d;
  logic [15:0]     pend_left_q, pend_left_d;
  frame_s          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [31:0]     acc_q, acc_d;
  rate_sel_e       last_rsel_q, last_rsel_d;
  logic [15:0]     out_left_q, out_left_d, out_right_q, out_right_d;
  logic            out_valid_q, out_valid_d, underflow_q, underflow_d;

  logic            accept, mono_path, push, pop, tick, empty;
  frame_s          push_frame, head;
  logic [31:0]     acc_sum;

  always_comb begin
    empty      = (level_q == '0);
    accept     = in_write && !strobe_q && !flush && (level_q < LW'(DEPTH));
    // 16bps is always carried as stereo pairs, even if the header says mono
    mono_path  = (in_coding.chan == kMono) && (in_coding.bps != k16Bps);
    push       = accept && (mono_path || (in_channel && pend_q));
    push_frame.left  = mono_path ? in_sample : pend_left_q;
    push_frame.right = in_sample;
    push_frame.rsel  = rate_sel_f(in_coding);

    head    = mem_q[rd_ptr_q];
    acc_sum = acc_q + rate_hz_f(empty ? last_rsel_q : head.rsel);
    tick    = (acc_sum >= CLK_HZ);
    pop     = tick && !empty && !flush;
  end

  always_comb begin
    strobe_d    = accept;
    pend_d      = pend_q;
    pend_left_d = pend_left_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    acc_d       = tick ? acc_sum - CLK_HZ : acc_sum;
    last_rsel_d = last_rsel_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    out_valid_d = pop;
    underflow_d = tick && empty && !flush;

    if (accept && !mono_path) begin
      if (!in_channel) begin
        pend_d      = 1'b1;
        pend_left_d = in_sample;
      end else begin
        pend_d      = 1'b0;
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      last_rsel_d = head.rsel;
      out_left_d  = head.left;
      out_right_d = head.right;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (flush) begin
      pend_d      = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      acc_d       = '0;
      out_left_d  = '0;
      out_right_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_left_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      acc_q       <= '0;
      last_rsel_q <= RSEL_37800;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      strobe_q    <= strobe_d;
      pend_q      <= pend_d;
      pend_left_q <= pend_left_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      acc_q       <= acc_d;
      last_rsel_q <= last_rsel_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      out_valid_q <= out_valid_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_frame;
  end

  assign in_strobe  = strobe_q;
  assign out_left   = out_left_q;
  assign out_right  = out_right_q;
  assign out_valid  = out_valid_q;
  assign underflow  = underflow_q;
  assign fifo_level = level_q;
endmodule

// File: tb/tb_audio_frame_pacer.sv
// Scoreboard bench for audio_frame_pacer: expected frames are queued as the
// samples are driven and checked as the pacer releases them.
module tb_audio_frame_pacer;
  import audio_frame_pacer_pkg::*;

  localparam int unsigned CLK_HZ = 3_780_000;  // 37.8 kHz tick every 100 cycles
  localparam int unsigned DEPTH  = 8;
  localparam int LW = $clog2(DEPTH) + 1;

  logic               clk, reset;
  logic signed [15:0] in_sample;
  logic               in_write, in_strobe, in_channel, flush;
  header_coding_s     in_coding;
  logic signed [15:0] out_left, out_right;
  logic               out_valid, underflow;
  logic [LW-1:0]      fifo_level;

  audio_frame_pacer #(.CLK_HZ(CLK_HZ), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_write(in_write),
    .in_strobe(in_strobe), .in_channel(in_channel), .in_coding(in_coding),
    .flush(flush), .out_left(out_left), .out_right(out_right),
    .out_valid(out_valid), .underflow(underflow), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  int valid_cnt = 0, uf_cnt = 0, dbl_cnt = 0;
  int prev_vcyc = -1, last_space = 0, space_bad = 0;
  bit chk_space = 0, prev_strobe = 0;
  logic [31:0] exp_q[$];
  header_coding_s st, mo;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin : monitor
    logic [31:0] e;
    @(negedge clk);
    if (reset) prev_strobe = 0;
    else begin
      if (in_strobe && prev_strobe) dbl_cnt++;
      prev_strobe = in_strobe;
      if (underflow) uf_cnt++;
      if (out_valid) begin
        valid_cnt++;
        if (prev_vcyc >= 0) begin
          last_space = cyc - prev_vcyc;
          if (chk_space && last_space != 100) space_bad++;
        end
        prev_vcyc = cyc;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_unexpected: got %h, no frame expected", {out_left, out_right});
        end else begin
          e = exp_q.pop_front();
          if ({out_left, out_right} !== e) begin
            n_fail++;
            $display("FAIL frame_data: got %h, expected %h", {out_left, out_right}, e);
          end
        end
      end
    end
  end

  task automatic send(input logic signed [15:0] s, input logic ch, input header_coding_s c);
    bit got = 0;
    @(negedge clk);
    in_sample = s; in_channel = ch; in_coding = c; in_write = 1'b1;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(posedge clk); #1;
      if (in_strobe) got = 1;
    end
    in_write = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: sample %h got no strobe, expected one", s);
    end
  endtask

  task automatic do_flush(output int fcyc);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    fcyc = cyc;
  endtask

  task automatic wait_drain(input int maxc, input string name);
    for (int k = 0; k < maxc && exp_q.size() != 0; k++) @(posedge clk);
    @(posedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d frames still pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_write = 0; flush = 0; in_sample = 0; in_channel = 0; in_coding = st;
    #1;
    n_tests++;
    if ({in_strobe, out_valid, underflow} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b, expected 000", {in_strobe, out_valid, underflow});
    end
    n_tests++;
    if ({out_left, out_right} !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, expected 0", {out_left, out_right});
    end
    n_tests++;
    if (fifo_level !== '0) begin
      n_fail++; $display("FAIL reset_level: got %0d, expected 0", fifo_level);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_stereo();
    int f; int v0;
    logic signed [15:0] l, r;
    do_flush(f);
    prev_vcyc = -1; chk_space = 1; space_bad = 0; v0 = valid_cnt;
    for (int i = 1; i <= 100; i++) begin
      l = 16'(i); r = -l;
      exp_q.push_back({l, r});
      send(l, 1'b0, st);
      send(r, 1'b1, st);
    end
    wait_drain(2000, "stereo");
    chk_space = 0;
    n_tests++;
    if (valid_cnt - v0 != 100) begin
      n_fail++; $display("FAIL stereo_count: got %0d frames, expected 100", valid_cnt - v0);
    end
    n_tests++;
    if (space_bad != 0) begin
      n_fail++; $display("FAIL stereo_spacing: %0d gaps differ from 100 cycles, expected 0", space_bad);
    end
  endtask

  task automatic test_mono();
    int f; int v0;
    do_flush(f);
    v0 = valid_cnt;
    exp_q.push_back(32'h1234_1234);
    send(16'sh1234, 1'b0, mo);
    exp_q.push_back(32'h7FFF_7FFF);
    send(16'sh7FFF, 1'b1, mo);
    wait_drain(800, "mono");
    n_tests++;
    if (valid_cnt - v0 != 2) begin
      n_fail++; $display("FAIL mono_count: got %0d frames, expected 2", valid_cnt - v0);
    end
    n_tests++;
    if (last_space != 199 && last_space != 200) begin
      n_fail++; $display("FAIL mono_spacing: got %0d cycles, expected 199 or 200", last_space);
    end
  endtask

  task automatic test_handshake();
    int f; int scyc; bit got; bit prev_ov; bit ov_before;
    logic signed [15:0] l;
    do_flush(f);
    for (int i = 0; i < int'(DEPTH); i++) begin
      l = 16'(16'h100 + i);
      exp_q.push_back({l, ~l});
      send(l, 1'b0, st);
      send(~l, 1'b1, st);
    end
    #1;
    n_tests++;
    if (fifo_level !== LW'(DEPTH)) begin
      n_fail++; $display("FAIL hs_full_level: got %0d, expected %0d", fifo_level, DEPTH);
    end
    @(negedge clk);
    in_sample = 16'sh0055; in_channel = 1'b0; in_coding = st; in_write = 1'b1;
    got = 0; prev_ov = 0; ov_before = 0; scyc = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge clk); #1;
      if (in_strobe) begin got = 1; ov_before = prev_ov; scyc = cyc; end
      prev_ov = out_valid;
    end
    in_write = 1'b0;
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL hs_strobe: got no strobe, expected one after first pop");
    end
    n_tests++;
    if (!ov_before) begin
      n_fail++; $display("FAIL hs_strobe_timing: strobe at cycle %0d not right after a pop, expected right after", scyc);
    end
    repeat (5) @(posedge clk);
    do_flush(f);
  endtask

  task automatic test_pairing();
    int f;
    do_flush(f);
    exp_q.push_back({16'sd7, 16'sd9});
    send(16'sd5, 1'b0, st);
    send(16'sd7, 1'b0, st);
    send(16'sd9, 1'b1, st);
    send(16'sd11, 1'b1, st);
    #1;
    n_tests++;
    if (fifo_level !== LW'(1)) begin
      n_fail++; $display("FAIL pair_level: got %0d, expected 1", fifo_level);
    end
    wait_drain(300, "pair");
    n_tests++;
    if (fifo_level !== '0) begin
      n_fail++; $display("FAIL pair_level_after: got %0d, expected 0", fifo_level);
    end
  endtask

  task automatic test_underflow();
    int f; int v0; int u0;
    do_flush(f);
    v0 = valid_cnt; u0 = uf_cnt;
    exp_q.push_back({16'sd100, -16'sd100});
    send(16'sd100, 1'b0, st);
    send(-16'sd100, 1'b1, st);
    while (cyc < f + 250) @(posedge clk);
    #1;
    n_tests++;
    if (valid_cnt - v0 != 1) begin
      n_fail++; $display("FAIL uf_valid_count: got %0d, expected 1", valid_cnt - v0);
    end
    n_tests++;
    if (uf_cnt - u0 != 1) begin
      n_fail++; $display("FAIL uf_count: got %0d, expected 1", uf_cnt - u0);
    end
    n_tests++;
    if ({out_left, out_right} !== {16'sd100, -16'sd100}) begin
      n_fail++; $display("FAIL uf_hold: got %h, expected %h", {out_left, out_right}, {16'sd100, -16'sd100});
    end
  endtask

  task automatic test_flush();
    int f;
    do_flush(f);
    exp_q.push_back({16'sd1, 16'sd2});
    send(16'sd1, 1'b0, st); send(16'sd2, 1'b1, st);
    exp_q.push_back({16'sd3, 16'sd4});
    send(16'sd3, 1'b0, st); send(16'sd4, 1'b1, st);
    while (cyc < f + 99) @(posedge clk);
    #1;
    flush = 1'b1; in_write = 1'b1; in_sample = 16'sd77; in_channel = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    n_tests++;
    if (in_strobe !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_pulses: strobe=%b valid=%b, expected 0 0", in_strobe, out_valid);
    end
    n_tests++;
    if (fifo_level !== '0) begin
      n_fail++; $display("FAIL flush_level: got %0d, expected 0", fifo_level);
    end
    n_tests++;
    if ({out_left, out_right} !== 32'h0) begin
      n_fail++; $display("FAIL flush_outputs: got %h, expected 0", {out_left, out_right});
    end
    flush = 1'b0; in_write = 1'b0;
  endtask

  task automatic test_async_reset();
    int f; int v0;
    do_flush(f);
    v0 = valid_cnt;
    exp_q.push_back({16'sh0ABC, 16'sh0DEF});
    send(16'sh0ABC, 1'b0, st); send(16'sh0DEF, 1'b1, st);
    for (int k = 0; k < 300 && valid_cnt == v0; k++) @(posedge clk);
    @(negedge clk);
    in_sample = 16'sd42; in_channel = 1'b0; in_write = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (in_strobe !== 1'b1) begin
      n_fail++; $display("FAIL ar_strobe_pre: got %b, expected 1", in_strobe);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({in_strobe, out_left, out_right} !== 33'h0) begin
      n_fail++; $display("FAIL ar_outputs: got strobe=%b out=%h, expected 0", in_strobe, {out_left, out_right});
    end
    n_tests++;
    if (fifo_level !== '0) begin
      n_fail++; $display("FAIL ar_level: got %0d, expected 0", fifo_level);
    end
    in_write = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_no_double();
    n_tests++;
    if (dbl_cnt !== 0) begin
      n_fail++; $display("FAIL double_strobe: got %0d back-to-back strobes, expected 0", dbl_cnt);
    end
  endtask

  initial begin
    st.chan = kStereo; st.rate = kRate37_8; st.bps = k4Bps;
    mo.chan = kMono;   mo.rate = kRate18_9; mo.bps = k4Bps;
    test_reset();
    test_stereo();
    test_mono();
    test_handshake();
    test_pairing();
    test_underflow();
    test_flush();
    test_async_reset();
    test_no_double();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
